pe_edge_collector: RTL and testbench

- Downstream drain stage for a row or column of mesh PEs.
- After the mesh finishes a sort step, snapshots the N edge PEs' o_PE words ({addr, data}) and streams them out one per handshake over a valid/ready interface, tagged with the source PE index.
- Feeds result checkers, UART/host bridges or the next mesh pass.

---
 rtl/pe_edge_collector_if.sv | 25 ++
 rtl/pe_edge_collector.sv | 151 +++++++++++++++
 tb/tb_pe_edge_collector.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_edge_collector_if.sv
// Word stream from the edge collector to its consumer.
// Producer raises o_valid; consumer accepts with i_ready.
interface pe_edge_collector_if #(
  parameter int W  = 6,
  parameter int IW = 2
) ();
  logic          o_valid;
  logic          i_ready;
  logic [W-1:0]  o_data;
  logic [IW-1:0] o_index;

  modport master (
    output o_valid,
    output o_data,
    output o_index,
    input  i_ready
  );

  modport slave (
    input  o_valid,
    input  o_data,
    input  o_index,
    output i_ready
  );
endinterface

// File: rtl/pe_edge_collector.sv
// Edge PE collector: snapshots N mesh edge words, drains them.
// Optional macro PE_SKIP_ZERO_EN skips words whose data is 0.
module pe_edge_collector #(
  parameter int N             = 4,
  parameter int ADDR_WIDTH    = 3,
  parameter int DATA_WIDTH    = 3,
  parameter int IDX_WIDTH     = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [N*(ADDR_WIDTH+DATA_WIDTH)-1:0] i_PE_bus,
  pe_edge_collector_if.master  m_if,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int W  = ADDR_WIDTH + DATA_WIDTH;
  localparam int CW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT =
    (SETTLE_CYCLES > 0) ? CW'(SETTLE_CYCLES - 1) : '0;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]           r_state;
  logic [CW-1:0]        r_cnt;
  logic [IDX_WIDTH-1:0] r_idx;
  logic [W-1:0]         r_bank [N];
  logic [N-1:0]         r_elig;

  logic [W-1:0]         w_word [N];
  logic [N-1:0]         w_bus_elig;
  logic                 w_snap;
  logic                 w_first_found;
  logic [IDX_WIDTH-1:0] w_first_idx;
  logic                 w_next_found;
  logic [IDX_WIDTH-1:0] w_next_idx;
  logic                 w_valid;
  logic                 w_fire;

  // Split the flat bus into words and mark which are drainable.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_word[i] = i_PE_bus[i*W +: W];
`ifdef PE_SKIP_ZERO_EN
      w_bus_elig[i] = |w_word[i][DATA_WIDTH-1:0];
`else
      w_bus_elig[i] = 1'b1;
`endif
    end
  end

  // Snapshot edge: end of settle, or the start edge itself.
  always_comb begin
    w_snap = 1'b0;
    if (r_state == S_SETTLE && r_cnt == LAST_CNT)
      w_snap = 1'b1;
    if (SETTLE_CYCLES == 0 && r_state == S_IDLE && i_start)
      w_snap = 1'b1;
  end

  // Lowest eligible entry of the incoming bus.
  always_comb begin
    w_first_found = 1'b0;
    w_first_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_bus_elig[i]) begin
        w_first_found = 1'b1;
        w_first_idx   = IDX_WIDTH'(i);
      end
    end
  end

  // Lowest eligible bank entry above the current index.
  always_comb begin
    w_next_found = 1'b0;
    w_next_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (r_elig[i] && (IDX_WIDTH'(i) > r_idx)) begin
        w_next_found = 1'b1;
        w_next_idx   = IDX_WIDTH'(i);
      end
    end
  end

  assign w_valid = (r_state == S_DRAIN);
  assign w_fire  = w_valid && m_if.i_ready;

  // Control FSM: settle counter, drain index and state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else if (w_snap) begin
      r_cnt   <= '0;
      r_idx   <= w_first_idx;
      r_state <= w_first_found ? S_DRAIN : S_DONE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_cnt   <= '0;
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          r_cnt <= r_cnt + 1'b1;
        end
        S_DRAIN: begin
          if (w_fire) begin
            if (w_next_found)
              r_idx <= w_next_idx;
            else
              r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_idx   <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Snapshot bank: captured once per run, frozen while draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_elig <= '0;
      for (int i = 0; i < N; i++)
        r_bank[i] <= '0;
    end else if (w_snap) begin
      r_elig <= w_bus_elig;
      for (int i = 0; i < N; i++)
        r_bank[i] <= w_word[i];
    end
  end

  assign m_if.o_valid = w_valid;
  assign m_if.o_data  = w_valid ? r_bank[r_idx] : '0;
  assign m_if.o_index = w_valid ? r_idx : '0;
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = (r_state == S_DONE);

endmodule

// File: tb/tb_pe_edge_collector.sv
// Scoreboard bench for pe_edge_collector.
// Expected words queued at stimulus, popped on handshakes.
module tb_pe_edge_collector;

  localparam int N  = 4;
  localparam int W  = 6;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            i_start = 1'b0;
  logic [N*W-1:0]  i_PE_bus = '0;
  logic            o_busy;
  logic            o_done;

  int n_chk  = 0;
  int n_fail = 0;
  int n_done = 0;
  int n_acc  = 0;
  int ready_mode = 0;
  int cyc = 0;

  logic [W+IW-1:0] sb [$];

  pe_edge_collector_if #(.W(W), .IW(IW)) m_if ();

  pe_edge_collector #(
    .N(N), .ADDR_WIDTH(3), .DATA_WIDTH(3),
    .IDX_WIDTH(IW), .SETTLE_CYCLES(1)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .i_PE_bus(i_PE_bus), .m_if(m_if),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*W-1:0] mk_bus(
    input logic [W-1:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic push_bus(input logic [N*W-1:0] b);
    logic [W-1:0] w;
    for (int i = 0; i < N; i++) begin
      w = b[i*W +: W];
`ifdef PE_SKIP_ZERO_EN
      if (w[2:0] != 3'd0)
        sb.push_back({w, IW'(i)});
`else
      sb.push_back({w, IW'(i)});
`endif
    end
  endtask

  // Drive i_ready per mode, wait for o_done, then verify run end.
  task automatic wait_done(input string tag, input int start_at);
    int d0;
    bit got;
    d0 = n_done;
    got = 0;
    for (int c = 0; c < 60; c++) begin
      if (ready_mode == 1)
        m_if.i_ready = (cyc % 3 == 0);
      else
        m_if.i_ready = 1'b1;
      i_start = (c == start_at);
      cyc++;
      tick();
      if (n_done != d0) begin
        got = 1;
        break;
      end
    end
    i_start = 1'b0;
    m_if.i_ready = 1'b1;
    if (!got)
      check({tag, "_timeout"}, 0, 1);
    repeat (4) tick();
    check({tag, "_done_cnt"}, n_done - d0, 1);
    check({tag, "_busy_end"}, o_busy, 0);
    check({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  // Monitor: scoreboard pops, hold stability, idle zeros, done count.
  initial begin
    logic            stall;
    logic [W+IW-1:0] held;
    logic [W+IW-1:0] e;
    stall = 0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 0;
      end else begin
        if (o_done) n_done++;
        if (stall)
          check("hold", {m_if.o_data, m_if.o_index}, held);
        if (m_if.o_valid && m_if.i_ready) begin
          n_acc++;
          if (sb.size() == 0) begin
            check("unexpected_word", 1, 0);
          end else begin
            e = sb.pop_front();
            check("data", m_if.o_data, e[W+IW-1:IW]);
            check("index", m_if.o_index, e[IW-1:0]);
          end
        end
        if (!m_if.o_valid)
          check("idle_zero", {m_if.o_data, m_if.o_index}, 0);
        stall = m_if.o_valid && !m_if.i_ready;
        held  = {m_if.o_data, m_if.o_index};
      end
    end
  end

  initial begin
    logic [N*W-1:0] b_seq;
    logic [N*W-1:0] b_one;
    int a0;
    bit hit;
    b_seq = mk_bus(6'o01, 6'o02, 6'o03, 6'o04);
    b_one = '1;
    m_if.i_ready = 1'b1;

    // Reset held with i_start high.
    rst = 1'b1;
    i_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_out", {m_if.o_valid, o_busy, o_done,
                        m_if.o_data, m_if.o_index}, 0);
    end
    rst = 1'b0;
    i_start = 1'b0;
    tick();
    check("post_rst_busy", o_busy, 0);

    // Run A: full-rate drain and first-valid latency.
    i_PE_bus = b_seq;
    push_bus(b_seq);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("lat_e0_valid", m_if.o_valid, 0);
    check("lat_e0_busy", o_busy, 1);
    tick();
    check("lat_e1_valid", m_if.o_valid, 1);
    wait_done("runA", -1);

    // Run B: i_ready pattern 1,0,0,...
    ready_mode = 1;
    cyc = 0;
    push_bus(b_seq);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_done("runB", -1);
    ready_mode = 0;

    // Run C: bus overwritten after the snapshot edge.
    push_bus(b_seq);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    i_PE_bus = b_one;
    wait_done("runC", -1);
    i_PE_bus = b_seq;

    // Run D: restart pulse during drain is ignored.
    push_bus(b_seq);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    wait_done("runD", 1);

    // Run E: reset after the second accepted word.
    push_bus(b_seq);
    a0 = n_acc;
    hit = 0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (n_acc - a0 >= 2) begin
        hit = 1;
        break;
      end
    end
    if (!hit) check("runE_timeout", 0, 1);
    rst = 1'b1;
    tick();
    check("runE_rst_out", {m_if.o_valid, o_busy, o_done,
                           m_if.o_data, m_if.o_index}, 0);
    sb.delete();
    rst = 1'b0;
    tick();
    check("runE_no_done", o_done, 0);
    push_bus(b_seq);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_done("runE2", -1);

`ifdef PE_SKIP_ZERO_EN
    // Skip-zero: only data-nonzero entries drain.
    i_PE_bus = mk_bus(6'o20, 6'o05, 6'o10, 6'o36);
    push_bus(i_PE_bus);
    check("skip_sb_len", sb.size(), 2);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_done("skip", -1);

    // All-zero data: DONE straight after the snapshot edge.
    i_PE_bus = mk_bus(6'o10, 6'o20, 6'o30, 6'o00);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    check("zero_valid", m_if.o_valid, 0);
    check("zero_done", o_done, 1);
    tick();
    check("zero_done_off", o_done, 0);
    check("zero_busy_off", o_busy, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
